// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FIFO controller over one single-port BRAM with a registered output word.
// Reads take priority for the BRAM port, but can only be issued every other cycle, so writes always progress.
module bram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic                  o_bram_write,
  output logic [DATA_WIDTH-1:0] o_bram_data,
  input  logic [DATA_WIDTH-1:0] i_bram_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic                  rd_inflight;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] data_hold;

  logic rd_issue;
  logic wr_ready;
  logic wr_accept;
  logic pop;

  // A read is only launched when the output register will be free by the time the BRAM data lands.
  assign rd_issue  = !i_areset && (mem_count != '0) && !rd_inflight && (!rd_valid_q || i_rd_ready);
  assign wr_ready  = !i_areset && (mem_count != FULL_COUNT) && !rd_issue;
  assign wr_accept = i_wr_valid && wr_ready;
  assign pop       = rd_valid_q && i_rd_ready;

  assign o_wr_ready   = wr_ready;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_count      = mem_count;
  assign o_bram_write = wr_accept;
  assign o_bram_addr  = rd_issue ? rd_ptr : (wr_accept ? wr_ptr : addr_hold);
  assign o_bram_data  = wr_accept ? i_wr_data : data_hold;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      rd_inflight <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      addr_hold   <= '0;
      data_hold   <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        mem_count <= mem_count - 1'b1;
        addr_hold <= rd_ptr;
      end else if (wr_accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        mem_count <= mem_count + 1'b1;
        addr_hold <= wr_ptr;
        data_hold <= i_wr_data;
      end

      rd_inflight <= rd_issue;

      // Capture wins over a simultaneous pop: the popped word is replaced by the arriving one.
      if (rd_inflight) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= i_bram_data;
      end else if (pop) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - randomized self-checking bench for bram_fifo_ctrl with a behavioural BRAM.
module tb_bram_fifo_ctrl;

  localparam int AW = 8;
  localparam int DW = 64;

  logic          i_clk = 1'b0;
  logic          i_areset = 1'b1;
  logic          i_wr_valid = 1'b0;
  logic          o_wr_ready;
  logic [DW-1:0] i_wr_data = '0;
  logic          o_rd_valid;
  logic          i_rd_ready = 1'b0;
  logic [DW-1:0] o_rd_data;
  logic [AW:0]   o_count;
  logic [AW-1:0] o_bram_addr;
  logic          o_bram_write;
  logic [DW-1:0] o_bram_data;
  logic [DW-1:0] i_bram_data;

  bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_areset(i_areset),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_count(o_count), .o_bram_addr(o_bram_addr), .o_bram_write(o_bram_write),
    .o_bram_data(o_bram_data), .i_bram_data(i_bram_data)
  );

  always #5 i_clk = ~i_clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] bram_q = '0;
  assign i_bram_data = bram_q;
  always @(posedge i_clk) begin
    if (o_bram_write) mem[o_bram_addr] <= o_bram_data;
    else bram_q <= mem[o_bram_addr];
  end

  int n_checks = 0;
  int n_fail = 0;

  bit            s_acc, s_pop, s_rd_valid, s_wr_ready, s_bwrite;
  logic [DW-1:0] s_rd_data;
  logic [AW-1:0] s_addr;
  logic [AW:0]   s_count;
  logic [DW-1:0] got_q[$];

  task automatic run_cycle(input bit rst, input bit wv, input logic [DW-1:0] wd, input bit rr);
    @(negedge i_clk);
    i_areset = rst; i_wr_valid = wv; i_wr_data = wd; i_rd_ready = rr;
    #1;
    s_wr_ready = o_wr_ready;
    s_acc      = wv && o_wr_ready;
    s_rd_valid = o_rd_valid;
    s_pop      = o_rd_valid && rr;
    s_rd_data  = o_rd_data;
    s_count    = o_count;
    s_addr     = o_bram_addr;
    s_bwrite   = o_bram_write;
    if (s_pop) got_q.push_back(o_rd_data);
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 1'b0, '0, 1'b0);
    run_cycle(1'b1, 1'b0, '0, 1'b0);
    got_q.delete();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom} | 64'd1;
  endfunction

  task automatic test_reset();
    run_cycle(1'b1, 1'b1, rnd_word(), 1'b1);
    run_cycle(1'b1, 1'b1, rnd_word(), 1'b1);
    run_cycle(1'b1, 1'b1, rnd_word(), 1'b1);
    n_checks++; if (s_wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %0d expected 0", s_wr_ready); end
    n_checks++; if (s_bwrite !== 1'b0) begin n_fail++; $display("FAIL reset_bram_write: got %0d expected 0", s_bwrite); end
    n_checks++; if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0d expected 0", s_rd_valid); end
    n_checks++; if (s_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", s_count); end
    n_checks++; if (s_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", s_rd_data); end
    got_q.delete();
  endtask

  task automatic test_basic_order();
    logic [DW-1:0] words [2];
    logic [DW-1:0] wd;
    int idx, c0, cv;
    logic [AW-1:0] a0;
    bit w0;
    words[0] = 64'hdeadbeef00000000;
    words[1] = 64'habad1deac0fef00d;
    idx = 0; c0 = -1; cv = -1; a0 = '1; w0 = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      wd = (idx < 2) ? words[idx] : '0;
      run_cycle(1'b0, idx < 2, wd, 1'b1);
      if (s_rd_valid && cv < 0) cv = c;
      if (s_acc) begin
        if (idx == 0) begin c0 = c; a0 = s_addr; w0 = s_bwrite; end
        idx++;
      end
    end
    n_checks++; if (idx != 2) begin n_fail++; $display("FAIL basic_accepted: got %0d expected 2", idx); end
    n_checks++; if (a0 !== 8'd0 || w0 !== 1'b1) begin n_fail++; $display("FAIL basic_first_addr: got addr %0d write %0d expected addr 0 write 1", a0, w0); end
    n_checks++; if (cv - c0 != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", cv - c0); end
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL basic_pops: got %0d expected 2", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== words[0]) begin n_fail++; $display("FAIL basic_word0: got %h expected %h", got_q[0], words[0]); end
      n_checks++; if (got_q[1] !== words[1]) begin n_fail++; $display("FAIL basic_word1: got %h expected %h", got_q[1], words[1]); end
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] wd;
    int acc, acc2;
    acc = 0; acc2 = 0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      wd = rnd_word();
      run_cycle(1'b0, 1'b1, wd, 1'b0);
      if (s_acc) begin acc++; sent.push_back(wd); end
    end
    n_checks++; if (acc != 257) begin n_fail++; $display("FAIL full_accepted: got %0d expected 257", acc); end
    run_cycle(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (s_wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %0d expected 0", s_wr_ready); end
    n_checks++; if (s_count !== 9'd256) begin n_fail++; $display("FAIL full_count: got %0d expected 256", s_count); end
    run_cycle(1'b0, 1'b1, rnd_word(), 1'b1);
    if (s_acc) acc2++;
    for (int c = 0; c < 12; c++) begin
      run_cycle(1'b0, 1'b1, rnd_word(), 1'b0);
      if (s_acc) acc2++;
    end
    n_checks++; if (acc2 != 1) begin n_fail++; $display("FAIL full_refill: got %0d expected 1", acc2); end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== sent[0]) begin n_fail++; $display("FAIL full_pop_word: got %0d pops first %h expected 1 pop %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, sent[0]); end
    n_checks++; if (s_count !== 9'd256) begin n_fail++; $display("FAIL full_count_after: got %0d expected 256", s_count); end
  endtask

  task automatic test_wrap();
    int sent, addr_err, order_err;
    bit wv, rr, wrapped;
    sent = 0; addr_err = 0; order_err = 0; wrapped = 1'b0;
    do_reset();
    for (int c = 0; c < 6000 && got_q.size() < 600; c++) begin
      wv = (sent < 600) && ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      run_cycle(1'b0, wv, 64'(sent), rr);
      if (s_acc) begin
        if (s_addr !== 8'(sent) || s_bwrite !== 1'b1) addr_err++;
        if (sent >= 256 && s_addr == 8'd0) wrapped = 1'b1;
        sent++;
      end
    end
    n_checks++; if (got_q.size() != 600) begin n_fail++; $display("FAIL wrap_received: got %0d expected 600", got_q.size()); end
    foreach (got_q[i]) if (got_q[i] !== 64'(i)) order_err++;
    n_checks++; if (order_err != 0) begin n_fail++; $display("FAIL wrap_order: got %0d wrong words expected 0", order_err); end
    n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL wrap_write_addr: got %0d bad addresses expected 0", addr_err); end
    n_checks++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_ptr: got %0d expected 1", wrapped); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] a, b;
    a = rnd_word(); b = rnd_word();
    do_reset();
    run_cycle(1'b0, 1'b1, a, 1'b0);
    n_checks++; if (s_acc !== 1'b1) begin n_fail++; $display("FAIL coll_first_acc: got %0d expected 1", s_acc); end
    run_cycle(1'b0, 1'b1, b, 1'b0);
    n_checks++; if (s_count !== 9'd1 || s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL coll_setup: got count %0d rd_valid %0d expected 1 0", s_count, s_rd_valid); end
    n_checks++; if (s_wr_ready !== 1'b0) begin n_fail++; $display("FAIL coll_wr_ready: got %0d expected 0", s_wr_ready); end
    n_checks++; if (s_bwrite !== 1'b0 || s_addr !== 8'd0) begin n_fail++; $display("FAIL coll_bram_read: got write %0d addr %0d expected 0 0", s_bwrite, s_addr); end
    run_cycle(1'b0, 1'b1, b, 1'b0);
    n_checks++; if (s_acc !== 1'b1 || s_addr !== 8'd1) begin n_fail++; $display("FAIL coll_next_write: got acc %0d addr %0d expected 1 1", s_acc, s_addr); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, held;
    int n, err;
    bit seen;
    a = rnd_word(); b = rnd_word(); n = 0; err = 0; seen = 1'b0;
    do_reset();
    for (int c = 0; c < 10 && n < 2; c++) begin
      run_cycle(1'b0, 1'b1, (n == 0) ? a : b, 1'b0);
      if (s_acc) n++;
    end
    for (int c = 0; c < 10 && !seen; c++) begin
      run_cycle(1'b0, 1'b0, '0, 1'b0);
      seen = s_rd_valid;
    end
    held = s_rd_data;
    n_checks++; if (!seen || held !== a) begin n_fail++; $display("FAIL bp_head: got valid %0d data %h expected 1 %h", seen, held, a); end
    for (int c = 0; c < 10; c++) begin
      run_cycle(1'b0, 1'b0, '0, 1'b0);
      if (s_rd_data !== a || s_rd_valid !== 1'b1 || s_count !== 9'd1 || s_bwrite !== 1'b0) err++;
    end
    n_checks++; if (err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", err); end
    for (int c = 0; c < 8; c++) run_cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (got_q.size() != 2 || got_q[0] !== a || got_q[1] !== b) begin n_fail++; $display("FAIL bp_drain: got %0d pops expected 2 in order %h %h", got_q.size(), a, b); end
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] a, c_word;
    int err;
    a = rnd_word(); c_word = rnd_word(); err = 0;
    do_reset();
    run_cycle(1'b0, 1'b1, a, 1'b0);
    run_cycle(1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (s_count !== 9'd1 || s_bwrite !== 1'b0 || s_addr !== 8'd0) begin n_fail++; $display("FAIL rmr_issue: got count %0d write %0d addr %0d expected 1 0 0", s_count, s_bwrite, s_addr); end
    run_cycle(1'b1, 1'b1, c_word, 1'b0);
    run_cycle(1'b1, 1'b1, c_word, 1'b0);
    n_checks++; if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_rd_valid: got %0d expected 0", s_rd_valid); end
    n_checks++; if (s_count !== '0) begin n_fail++; $display("FAIL rmr_count: got %0d expected 0", s_count); end
    n_checks++; if (s_rd_data !== '0) begin n_fail++; $display("FAIL rmr_rd_data: got %h expected 0", s_rd_data); end
    n_checks++; if (s_wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmr_wr_ready: got %0d expected 0", s_wr_ready); end
    run_cycle(1'b1, 1'b1, c_word, 1'b0);
    n_checks++; if (s_wr_ready !== 1'b0 || s_bwrite !== 1'b0) begin n_fail++; $display("FAIL rmr_wr_ready_held: got ready %0d write %0d expected 0 0", s_wr_ready, s_bwrite); end
    for (int c = 0; c < 4; c++) begin
      run_cycle(1'b0, 1'b0, '0, 1'b1);
      if (s_rd_valid !== 1'b0 || s_count !== '0) err++;
    end
    n_checks++; if (err != 0) begin n_fail++; $display("FAIL rmr_discard: got %0d bad cycles expected 0", err); end
    run_cycle(1'b0, 1'b1, c_word, 1'b1);
    for (int c = 0; c < 6; c++) run_cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== c_word) begin n_fail++; $display("FAIL rmr_after: got %0d pops expected 1 word %h", got_q.size(), c_word); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_full();
    test_wrap();
    test_collision();
    test_backpressure();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
